// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - multi-cycle slice-serial add/subtract with valid/ready handshakes
// Optional accumulate mode (A taken from last sum) under macro SERIAL_ADDSUB_ACCUM_EN.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SERIAL_ADDSUB_ACCUM_EN
  input  logic             acc,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] SL_MASK = {WIDTH{1'b1}} >> (WIDTH - SLICE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [31:0]       base;
  logic [WIDTH-1:0]  a_sh, b_sh, a_src;
  logic [SLICE-1:0]  a_sl, b_sl;
  logic [SLICE:0]    sl_res;
  logic              carry_into_msb;

`ifdef SERIAL_ADDSUB_ACCUM_EN
  assign a_src = acc ? sum_q : op_a;
`else
  assign a_src = op_a;
`endif

  always_comb begin
    base   = 32'(cnt_q) * 32'(SLICE);
    a_sh   = a_q >> base;
    b_sh   = b_q >> base;
    a_sl   = a_sh[SLICE-1:0];
    b_sl   = b_sh[SLICE-1:0];
    sl_res = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
    // Carry into a bit position is recovered as sum ^ a ^ b at that bit.
    carry_into_msb = a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ sl_res[SLICE-1];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_src;
          b_d     = sub ? ~op_b : op_b;
          carry_d = sub;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = (sum_q & ~(SL_MASK << base)) | (WIDTH'(sl_res[SLICE-1:0]) << base);
        carry_d = sl_res[SLICE];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          cout_d  = sl_res[SLICE];
          ovf_d   = carry_into_msb ^ sl_res[SLICE];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - directed self-checking bench for serial_addsub
// Covers add/sub, backpressure, mid-op reset, N=1 build and (when defined) SERIAL_ADDSUB_ACCUM_EN.
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [7:0]  op_a = '0, op_b = '0;
  logic        sub = 1'b0;
  logic        out_valid, out_ready = 1'b1;
  logic [7:0]  sum;
  logic        carry_out, overflow, busy;
`ifdef SERIAL_ADDSUB_ACCUM_EN
  logic        acc = 1'b0;
  logic        acc16 = 1'b0;
`endif

  logic        v16 = 1'b0, r16;
  logic [15:0] a16 = '0, b16 = '0, s16;
  logic        ov16, c16, o16, bz16;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .SLICE(2)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SERIAL_ADDSUB_ACCUM_EN
    .acc(acc),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a), .op_b(op_b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .carry_out(carry_out), .overflow(overflow), .busy(busy)
  );

  serial_addsub #(.WIDTH(16), .SLICE(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
`ifdef SERIAL_ADDSUB_ACCUM_EN
    .acc(acc16),
`endif
    .in_valid(v16), .in_ready(r16), .op_a(a16), .op_b(b16), .sub(1'b0),
    .out_valid(ov16), .out_ready(1'b1), .sum(s16),
    .carry_out(c16), .overflow(o16), .busy(bz16)
  );

  // Presents one operation, then scrambles the inputs and counts edges (accept edge included) to out_valid.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic ac, output int edges);
    @(negedge clk);
    op_a = a; op_b = b; sub = s; in_valid = 1'b1; out_ready = 1'b1;
`ifdef SERIAL_ADDSUB_ACCUM_EN
    acc = ac;
`else
    if (ac) $display("note: accumulate requested without accumulate build");
`endif
    @(negedge clk);
    in_valid = 1'b0; op_a = ~a; op_b = ~b; sub = ~s;
    edges = 1;
    while (!out_valid && edges < 20) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if ({sum, carry_out, overflow} !== 10'h0) begin bad++; $display("FAIL reset_outputs got=%h/%b/%b exp=00/0/0", sum, carry_out, overflow); end
    rst_n = 1'b1;
  endtask

  task automatic test_addsub();
    logic [7:0] va [6], vb [6], vs [6];
    logic       vsub [6], vc [6], vo [6];
    int e;
    va = '{8'h35, 8'hFF, 8'h7F, 8'h10, 8'h80, 8'h05};
    vb = '{8'h4A, 8'h01, 8'h01, 8'h20, 8'h01, 8'h05};
    vsub = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vs = '{8'h7F, 8'h00, 8'h80, 8'hF0, 8'h7F, 8'h00};
    vc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vo = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], vsub[i], 1'b0, e);
      total++; if (e !== 5) begin bad++; $display("FAIL addsub%0d_latency got=%0d exp=5", i, e); end
      total++; if (sum !== vs[i]) begin bad++; $display("FAIL addsub%0d_sum got=%h exp=%h", i, sum, vs[i]); end
      total++; if (carry_out !== vc[i]) begin bad++; $display("FAIL addsub%0d_carry got=%b exp=%b", i, carry_out, vc[i]); end
      total++; if (overflow !== vo[i]) begin bad++; $display("FAIL addsub%0d_ovf got=%b exp=%b", i, overflow, vo[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int e;
    @(negedge clk);
    op_a = 8'h12; op_b = 8'h34; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    e = 1;
    while (!out_valid && e < 20) begin @(negedge clk); e++; end
    total++; if (e !== 5) begin bad++; $display("FAIL bp_latency got=%0d exp=5", e); end
    op_a = 8'hAA; op_b = 8'h11; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid%0d got=%b exp=1", k, out_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready%0d got=%b exp=0", k, in_ready); end
      total++; if ({sum, carry_out, overflow} !== {8'h46, 2'b00}) begin bad++; $display("FAIL bp_stable%0d got=%h/%b/%b exp=46/0/0", k, sum, carry_out, overflow); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL bp_idle got=%b%b exp=01", out_valid, in_ready); end
    @(negedge clk);
    total++; if ({busy, in_ready} !== 2'b10) begin bad++; $display("FAIL bp_second_accept got=%b%b exp=10", busy, in_ready); end
    in_valid = 1'b0;
    e = 1;
    while (!out_valid && e < 20) begin @(negedge clk); e++; end
    total++; if (sum !== 8'hBB) begin bad++; $display("FAIL bp_second_sum got=%h exp=bb", sum); end
  endtask

  task automatic test_reset_mid_op();
    int e;
    @(negedge clk);
    op_a = 8'h33; op_b = 8'h44; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if ({out_valid, in_ready, busy} !== 3'b010) begin bad++; $display("FAIL abort_ctrl got=%b%b%b exp=010", out_valid, in_ready, busy); end
    total++; if (sum !== 8'h00) begin bad++; $display("FAIL abort_sum got=%h exp=00", sum); end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'h01, 8'h01, 1'b0, 1'b0, e);
    total++; if ({sum, carry_out} !== {8'h02, 1'b0}) begin bad++; $display("FAIL after_abort got=%h/%b exp=02/0", sum, carry_out); end
    @(negedge clk);
    a16 = 16'hFFFF; b16 = 16'h0001; v16 = 1'b1;
    @(negedge clk);
    v16 = 1'b0;
    e = 1;
    while (!ov16 && e < 20) begin @(negedge clk); e++; end
    total++; if (e !== 2) begin bad++; $display("FAIL w16_latency got=%0d exp=2", e); end
    total++; if ({s16, c16, o16} !== {16'h0000, 2'b10}) begin bad++; $display("FAIL w16_result got=%h/%b/%b exp=0000/1/0", s16, c16, o16); end
  endtask

`ifdef SERIAL_ADDSUB_ACCUM_EN
  task automatic test_accum();
    int e;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'hFF, 8'h05, 1'b0, 1'b1, e);
    total++; if (sum !== 8'h05) begin bad++; $display("FAIL acc1_sum got=%h exp=05", sum); end
    do_op(8'hFF, 8'h7C, 1'b0, 1'b1, e);
    total++; if ({sum, carry_out, overflow} !== {8'h81, 2'b01}) begin bad++; $display("FAIL acc2 got=%h/%b/%b exp=81/0/1", sum, carry_out, overflow); end
    do_op(8'hFF, 8'h01, 1'b1, 1'b1, e);
    total++; if ({sum, carry_out, overflow} !== {8'h80, 2'b10}) begin bad++; $display("FAIL acc3 got=%h/%b/%b exp=80/1/0", sum, carry_out, overflow); end
    acc = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_addsub();
    test_back_to_back();
    test_reset_mid_op();
`ifdef SERIAL_ADDSUB_ACCUM_EN
    test_accum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
